// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decode/branch units until consumed, and follows branch
// redirects. A redirect to a misaligned target parks the unit in FAULT.
//
// state | meaning
// IDLE  | one quiet cycle after reset before the first request
// FETCH | request outstanding at pc, waiting for imem_ready
// VALID | instruction latched, waiting for downstream to consume it
// FAULT | misaligned redirect seen; sticky until reset
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic [31:0] address,
  input  logic        stall,
  input  logic [31:0] next_inst,
  input  logic        redirect,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_nxt;
  logic [31:0] instr_q;
  logic [31:0] instr_nxt;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr_pc <= RESET_PC;
      instr_q  <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_pc <= instr_pc_nxt;
      instr_q  <= instr_nxt;
    end
  end

  // Next-state and datapath update; redirect only matters when a word is consumed.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_pc_nxt = instr_pc;
    instr_nxt    = instr_q;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_nxt    = imem_rdata;
          instr_pc_nxt = pc;
          pc_nxt       = pc + 32'd4;
          state_nxt    = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          state_nxt = FETCH;
          if (redirect) begin
            pc_nxt = next_inst;
            if (next_inst[1:0] != 2'b00) begin
              state_nxt = FAULT;
            end
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode directly from state and registers.
  assign imem_req    = (state == FETCH);
  assign inst_valid  = (state == VALID);
  assign fault       = (state == FAULT);
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign address     = instr_pc + 32'd4;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  instruction-memory word address, equal to pc register.
REQ-006 imem_ready  input  1  memory returns imem_rdata this cycle for the pending request.
REQ-007 imem_rdata  input  32  instruction word from memory.
REQ-008 instruction  output  32  latched instruction word to decode and branch units.
REQ-009 inst_valid  output  1  instruction holds a fetched, unconsumed word.
REQ-010 address  output  32  PC+4 of the latched instruction, driven to the branch unit's address input.
REQ-011 stall  input  1  downstream cannot accept the latched instruction this cycle.
REQ-012 next_inst  input  32  redirect target from the branch unit.
REQ-013 redirect  input  1  branch unit selects next_inst (taken branch or jump).
REQ-014 fault  output  1  sticky misaligned-target indicator.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, VALID, FAULT.
REQ-016 IDLE: imem_req=0, inst_valid=0; SHALL go to FETCH unconditionally on the next edge.
REQ-017 FETCH: imem_req=1, imem_addr=pc; SHALL hold imem_addr stable until imem_ready=1.
REQ-018 FETCH with imem_ready=1: SHALL load instruction<=imem_rdata and instr_pc<=pc, set pc<=pc+4, and go to VALID.
REQ-019 VALID: inst_valid=1, imem_req=0; instruction and address SHALL stay stable while stall=1.
REQ-020 A word SHALL be consumed on any edge where state=VALID and stall=0; state then goes to FETCH.
REQ-021 On consumption with redirect=1 and next_inst[1:0]==2'b00, pc SHALL load next_inst, overriding the pc+4 value.
REQ-022 On consumption with redirect=1 and next_inst[1:0]!=2'b00, state SHALL go to FAULT and pc SHALL load next_inst.
REQ-023 redirect SHALL be ignored in IDLE, FETCH, FAULT, and in VALID while stall=1.
REQ-024 FAULT: fault=1, imem_req=0, inst_valid=0; the FSM SHALL remain in FAULT until reset.
REQ-025 address SHALL equal instr_pc+4, computed modulo 2^32.
REQ-026 pc increment SHALL wrap mod 2^32: 32'hFFFF_FFFC+4 yields 32'h0000_0000.
REQ-027 imem_ready outside FETCH SHALL be ignored and imem_rdata discarded.
REQ-028 Minimum latency SHALL be 1 cycle from imem_req rising to inst_valid rising, given imem_ready=1 on the first FETCH cycle.
REQ-029 Sustained throughput with zero-wait memory and no stall SHALL be one instruction per 2 cycles.

Reset
REQ-030 rst_n=0 at an edge SHALL force state=IDLE, pc=RESET_PC, instr_pc=RESET_PC, instruction=0, inst_valid=0, fault=0, imem_req=0.
REQ-031 Reset asserted mid-FETCH SHALL abandon the outstanding request; any imem_ready in that cycle SHALL be ignored.
REQ-032 After reset release, address SHALL read RESET_PC+4 until the first instruction is latched.

Verification
REQ-033 Reset release with a zero-wait memory -> imem_addr sequence 0, 4, 8 on successive FETCH cycles, each word appearing on instruction with inst_valid=1 for one cycle.
REQ-034 Memory holding imem_ready=0 for 3 cycles at addr 8 -> imem_addr=8 stable for 4 cycles, inst_valid=0 throughout; word latched on the 4th cycle.
REQ-035 stall=1 for 2 cycles in VALID at instr_pc=4 -> instruction and address=8 unchanged, no imem_req; fetch of addr 8 follows stall release.
REQ-036 Consume at instr_pc=10 with redirect=1, next_inst=32'd8 -> next imem_addr=8; same test with stall=1 -> redirect ignored, pc stays 14.
REQ-037 Consume with redirect=1, next_inst=32'd30 -> fault=1, imem_req=0, inst_valid=0 held until rst_n=0 restores IDLE with pc=RESET_PC.
REQ-038 pc=32'hFFFF_FFFC fetch -> address=32'h0000_0000, next imem_addr=32'h0000_0000.
